// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the execute-stage divider front end.
//   - Micro-op encodings for DIV/MOD/DIVU/MODU.
//   - Controller state enum.
//   - Helpers that decode the op into "wants remainder" and "signed mode".
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MOD  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_MODU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  // True when the op returns the remainder rather than the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_MOD) || (op == OP_MODU);
  endfunction

  // True when the divider must run in signed mode.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_chk.sv
// div_issue_ctrl_chk: protocol checker for the divider launch interface.
//   clk, reset : clock and synchronous active-high reset
//   div_start  : launch pulse driven toward the divider
//   div_busy   : divider iterating
module div_issue_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic div_start,
  input logic div_busy
);

  // Launching into a busy divider would corrupt the division in progress.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (reset) !(div_start && div_busy)
  );

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage front end for the iterative divider.
//   Issue side  : in_valid/in_ready handshake with in_op, in_src1, in_src2, in_tag.
//   Flush       : flush kills queued, in-flight and held work.
//   Writeback   : out_valid/out_ready with out_result, out_tag, out_dbz.
//   Divider side: div_start pulse, div_signed, div_dividend, div_divisor out;
//                 div_busy, div_done, div_dbz, div_quotient, div_remainder in.
// The divider cannot be aborted, so a flush during WAIT parks in DRAIN until the
// divider's done pulse and throws that result away.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             div_start,
  output logic             div_signed,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_dbz,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder
);

  div_state_e       state_r;
  div_state_e       state_nxt_s;
  logic [1:0]       op_r;
  logic [XLEN-1:0]  src1_r;
  logic [XLEN-1:0]  src2_r;
  logic [TAG_W-1:0] tag_r;
  logic [XLEN-1:0]  result_r;
  logic [TAG_W-1:0] out_tag_r;
  logic             dbz_r;
  logic             out_valid_r;
  logic             in_ready_s;
  logic             div_start_s;
  logic             accept_s;
  logic             capture_s;

  assign accept_s  = in_valid & in_ready_s;
  // A done pulse that coincides with flush is discarded, never captured.
  assign capture_s = (state_r == ST_WAIT) & div_done & ~flush;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush outranks every other event in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_ISSUE;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (flush) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)         state_nxt_s = div_done ? ST_IDLE : ST_DRAIN;
        else if (div_done) state_nxt_s = ST_HOLD;
        else               state_nxt_s = ST_WAIT;
      end
      ST_HOLD: begin
        if (flush)          state_nxt_s = ST_IDLE;
        else if (out_ready) state_nxt_s = accept_s ? ST_ISSUE : ST_IDLE;
        else                state_nxt_s = ST_HOLD;
      end
      ST_DRAIN: begin
        if (div_done) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake and launch outputs decoded from the current state.
  always_comb begin
    in_ready_s  = 1'b0;
    div_start_s = 1'b0;
    case (state_r)
      ST_IDLE:  in_ready_s  = ~flush;
      ST_ISSUE: div_start_s = ~flush;
      // Back-to-back issue only when the held result leaves this same cycle.
      ST_HOLD:  in_ready_s  = out_ready & ~flush;
      default: begin
        in_ready_s  = 1'b0;
        div_start_s = 1'b0;
      end
    endcase
  end

  // Operand latch; stays stable from ISSUE through WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= 2'b00;
      src1_r <= {XLEN{1'b0}};
      src2_r <= {XLEN{1'b0}};
      tag_r  <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      op_r   <= in_op;
      src1_r <= in_src1;
      src2_r <= in_src2;
      tag_r  <= in_tag;
    end else begin
      op_r   <= op_r;
      src1_r <= src1_r;
      src2_r <= src2_r;
      tag_r  <= tag_r;
    end
  end

  // Result capture on done and registered valid toward writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == ST_HOLD);
      if (capture_s) begin
        result_r  <= op_is_rem(op_r) ? div_remainder : div_quotient;
        out_tag_r <= tag_r;
        dbz_r     <= div_dbz;
      end else begin
        result_r  <= result_r;
        out_tag_r <= out_tag_r;
        dbz_r     <= dbz_r;
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_r;
  assign out_result   = result_r;
  assign out_tag      = out_tag_r;
  assign out_dbz      = dbz_r;
  assign div_start    = div_start_s;
  assign div_signed   = op_is_signed(op_r);
  assign div_dividend = src1_r;
  assign div_divisor  = src2_r;

  div_issue_ctrl_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start_s),
    .div_busy  (div_busy)
  );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: plays the divider, drives directed then random
// micro-ops, and compares every cycle against a transaction-level model.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 5;
  localparam int MAX_CYCLES = 20000;
  localparam int N_RAND     = 300;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;
  logic             div_start;
  logic             div_signed;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic             div_busy;
  logic             div_done;
  logic             div_dbz;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;

  always #5 clk = ~clk;

  div_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_dbz(out_dbz),
    .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          flush_after;
    int          hold_ready;
    bit          has_lit;
    logic [31:0] lit;
    bit          lit_dbz;
  } item_t;

  typedef struct {
    logic [31:0] res;
    bit          dbz;
    logic [4:0]  tag;
    bit          has_lit;
    logic [31:0] lit;
    bit          lit_dbz;
    int          hold_ready;
  } exp_t;

  item_t inq[$];
  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural divide: returns {quotient, remainder}.
  function automatic logic [63:0] ref_qr(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; r = a;
    end else if (op[1]) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      q = sa / sb; r = sa % sb;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] ref_sel(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] qr;
    qr = ref_qr(op, a, b);
    return op[0] ? qr[31:0] : qr[63:32];
  endfunction

  function automatic item_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, input int fa, input int hr,
                               input bit hl, input logic [31:0] lit, input bit ld);
    item_t it;
    it.op = op; it.a = a; it.b = b; it.tag = tag;
    it.flush_after = fa; it.hold_ready = hr;
    it.has_lit = hl; it.lit = lit; it.lit_dbz = ld;
    return it;
  endfunction

  initial begin
    item_t       cur;
    item_t       it;
    exp_t        e;
    logic [63:0] qr;
    bit          directed;
    bit          pend_issue;
    bit          inflight;
    bit          live;
    bit          ov_exp;
    bit          exp_in_ready;
    bit          start_exp;
    bit          acc;
    bit          take;
    bit          done_live;
    bit          finished;
    bit          idle;
    int          dv_cnt;
    int          fl_cnt;
    logic [31:0] dv_q;
    logic [31:0] dv_r;
    bit          dv_dbz;

    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src1 = 32'd0; in_src2 = 32'd0;
    in_tag = 5'd0; flush = 1'b0; out_ready = 1'b1;
    div_busy = 1'b0; div_done = 1'b0; div_dbz = 1'b0;
    div_quotient = 32'd0; div_remainder = 32'd0;
    pend_issue = 1'b0; inflight = 1'b0; live = 1'b0; ov_exp = 1'b0;
    dv_cnt = 0; fl_cnt = 0; dv_q = 32'd0; dv_r = 32'd0; dv_dbz = 1'b0;
    directed = 1'b1; finished = 1'b0;
    cur = mk(2'b00, 32'd0, 32'd0, 5'd0, 0, 0, 1'b0, 32'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_out_dbz", out_dbz, 1'b0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", out_tag, 5'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_divisor", div_divisor, 32'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    inq.push_back(mk(OP_DIV,  32'd7,          32'd2,          5'd3,  0, 0, 1'b1, 32'd3,          1'b0));
    inq.push_back(mk(OP_MOD,  32'hFFFF_FFF9,  32'd2,          5'd4,  0, 0, 1'b1, 32'hFFFF_FFFF,  1'b0));
    inq.push_back(mk(OP_MODU, 32'hFFFF_FFF9,  32'd2,          5'd5,  0, 0, 1'b1, 32'h0000_0001,  1'b0));
    inq.push_back(mk(OP_DIV,  32'h1234,       32'd0,          5'd6,  0, 0, 1'b1, 32'd0,          1'b1));
    inq.push_back(mk(OP_MOD,  32'h1234,       32'd0,          5'd7,  0, 0, 1'b1, 32'h1234,       1'b1));
    inq.push_back(mk(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  0, 0, 1'b1, 32'h8000_0000,  1'b0));
    inq.push_back(mk(OP_DIVU, 32'd100,        32'd7,          5'd9,  3, 0, 1'b0, 32'd0,          1'b0));
    inq.push_back(mk(OP_DIV,  32'd100,        32'd7,          5'd10, 0, 0, 1'b1, 32'd14,         1'b0));
    inq.push_back(mk(OP_DIV,  32'd45,         32'd5,          5'd11, 0, 5, 1'b1, 32'd9,          1'b0));
    inq.push_back(mk(OP_DIVU, 32'd1000,       32'd10,         5'd12, 0, 0, 1'b1, 32'd100,        1'b0));
    foreach (inq[i]) begin
      if (inq[i].has_lit) chk("model_pin", ref_sel(inq[i].op, inq[i].a, inq[i].b), inq[i].lit);
    end

    for (int cyc = 0; cyc < MAX_CYCLES; cyc++) begin
      idle = (inq.size() == 0) && (exp_q.size() == 0) && !pend_issue && !inflight
             && !ov_exp && (dv_cnt == 0);
      if (idle && directed) begin
        directed = 1'b0;
        for (int n = 0; n < N_RAND; n++) begin
          it = mk(2'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 31),
                  5'($urandom), 0, 0, 1'b0, 32'd0, 1'b0);
          case ($urandom_range(0, 7))
            0: it.b = 32'd0;
            1: begin it.a = 32'h8000_0000; it.b = 32'hFFFF_FFFF; end
            2: begin it.a = 32'($urandom_range(0, 50)); it.b = 32'($urandom_range(1, 9)); end
            default: it.a = it.a;
          endcase
          inq.push_back(it);
        end
      end else if (idle) begin
        finished = 1'b1;
        break;
      end

      @(negedge clk);
      // Divider behaviour for this cycle.
      div_done = 1'b0;
      div_dbz  = 1'($urandom_range(0, 1));
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          div_done = 1'b1; div_busy = 1'b0; div_dbz = dv_dbz;
          div_quotient = dv_q; div_remainder = dv_r;
        end else begin
          div_busy = 1'b1;
        end
      end else begin
        div_busy = 1'b0;
      end

      // Flush and writeback backpressure.
      if (directed) begin
        flush = 1'b0;
        if (fl_cnt > 0) begin
          fl_cnt--;
          if (fl_cnt == 0) flush = 1'b1;
        end
        out_ready = 1'b1;
        if (ov_exp && exp_q.size() > 0 && exp_q[0].hold_ready > 0) begin
          out_ready = 1'b0;
          exp_q[0].hold_ready--;
        end
      end else begin
        flush     = ($urandom_range(0, 29) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end

      // Issue-side offer.
      if (inq.size() > 0 && (directed || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; in_op = inq[0].op; in_src1 = inq[0].a;
        in_src2 = inq[0].b; in_tag = inq[0].tag;
      end else begin
        in_valid = 1'b0; in_op = 2'($urandom); in_src1 = $urandom;
        in_src2 = $urandom; in_tag = 5'($urandom);
      end

      #1;
      exp_in_ready = !flush && (ov_exp ? out_ready : !(pend_issue || inflight));
      start_exp    = pend_issue && !flush;
      chk("in_ready", in_ready, exp_in_ready);
      chk("out_valid", out_valid, ov_exp);
      chk("div_start", div_start, start_exp);
      if (ov_exp && exp_q.size() > 0) begin
        chk("out_result", out_result, exp_q[0].res);
        chk("out_tag", out_tag, exp_q[0].tag);
        chk("out_dbz", out_dbz, exp_q[0].dbz);
      end
      if (start_exp) begin
        chk("div_signed", div_signed, !cur.op[1]);
        chk("div_dividend", div_dividend, cur.a);
        chk("div_divisor", div_divisor, cur.b);
      end else if (inflight && live) begin
        chk("dividend_stable", div_dividend, cur.a);
        chk("divisor_stable", div_divisor, cur.b);
      end

      acc       = in_valid && exp_in_ready;
      take      = ov_exp && out_ready && !flush;
      done_live = div_done && live && !flush;

      // The divider reacts to whatever launch the DUT really drives.
      if (div_start && dv_cnt == 0) begin
        qr     = ref_qr({!div_signed, 1'b0}, div_dividend, div_divisor);
        dv_q   = qr[63:32];
        dv_r   = qr[31:0];
        dv_dbz = (div_divisor == 32'd0);
        dv_cnt = dv_dbz ? 1 : (directed ? 6 : $urandom_range(2, 8));
        div_quotient  = $urandom;
        div_remainder = $urandom;
      end

      // Transaction-level model update.
      if (div_done) inflight = 1'b0;
      if (flush) begin
        exp_q.delete();
        ov_exp = 1'b0; pend_issue = 1'b0; live = 1'b0;
      end else begin
        if (take) begin
          if (exp_q[0].has_lit) begin
            chk("lit_result", out_result, exp_q[0].lit);
            chk("lit_dbz", out_dbz, exp_q[0].lit_dbz);
          end
          void'(exp_q.pop_front());
          ov_exp = 1'b0;
        end
        if (done_live) begin
          ov_exp = 1'b1; live = 1'b0;
        end
        if (start_exp) begin
          pend_issue = 1'b0; live = 1'b1; inflight = 1'b1;
          if (cur.flush_after > 0) fl_cnt = cur.flush_after;
        end
        if (acc) begin
          cur = inq.pop_front();
          e.res = ref_sel(cur.op, cur.a, cur.b);
          e.dbz = (cur.b == 32'd0);
          e.tag = cur.tag;
          e.has_lit = cur.has_lit; e.lit = cur.lit; e.lit_dbz = cur.lit_dbz;
          e.hold_ready = cur.hold_ready;
          exp_q.push_back(e);
          pend_issue = 1'b1;
        end
      end
    end

    chk("run_completed", finished, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
